// File: rtl/cpu_clock_ctrl.sv
// Clock-enable generator: CPU step enable from button/fast/slow sources with
// breakpoint halt/resume, plus a display-scan digit index on one system clock.
module cpu_clock_ctrl #(
    parameter int DIV_WIDTH     = 18,
    parameter int FAST_SHIFT    = 6,
    parameter int SLOW_SHIFT    = 15,
    parameter int SCAN_SHIFT    = 17,
    parameter int DEBOUNCE_BITS = 16,
    parameter int NUM_DIGITS    = 4,
    parameter int DIG_BITS      = 2
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic [1:0]            mode,
    input  logic                  step_btn_n,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  cpu_en,
    output logic                  cpu_phase,
    output logic                  halted,
    output logic [DIG_BITS-1:0]   dig_idx,
    output logic [NUM_DIGITS-1:0] dig_onehot
);

    typedef enum logic {RUN, HALTED} state_e;

    // Masks select the low SHIFT bits; OR-ing the rest high lets a tick be a full-width AND.
    localparam logic [DIV_WIDTH-1:0] FAST_MASK = {DIV_WIDTH{1'b1}} >> (DIV_WIDTH - FAST_SHIFT);
    localparam logic [DIV_WIDTH-1:0] SLOW_MASK = {DIV_WIDTH{1'b1}} >> (DIV_WIDTH - SLOW_SHIFT);
    localparam logic [DIV_WIDTH-1:0] SCAN_MASK = {DIV_WIDTH{1'b1}} >> (DIV_WIDTH - SCAN_SHIFT);

    logic [DIV_WIDTH-1:0]     cnt_q;
    logic                     fast_tick, slow_tick, scan_tick;

    logic                     s1_q, s2_q, deb_q, deb_prev_q, armed_q, step_pulse_q;
    logic [1:0]               vld_q;
    logic [DEBOUNCE_BITS-1:0] dcnt_q;

    state_e                   state_q;
    logic                     halted_q, cpu_en_q, phase_q;
    logic                     src_d;

    logic [DIG_BITS-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0]    onehot_q;

    assign fast_tick = &(cnt_q | ~FAST_MASK);
    assign slow_tick = &(cnt_q | ~SLOW_MASK);
    assign scan_tick = &(cnt_q | ~SCAN_MASK);

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
        end
    end

    // NOTE: the debounce count is cleared by reset, so a press in progress is discarded.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            vld_q        <= 2'b00;
            deb_q        <= 1'b1;
            deb_prev_q   <= 1'b1;
            dcnt_q       <= '0;
            armed_q      <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            s1_q       <= step_btn_n;
            s2_q       <= s1_q;
            vld_q      <= {vld_q[0], 1'b1};
            deb_prev_q <= deb_q;
            if (s2_q == deb_q) begin
                dcnt_q <= '0;
            end else if (&dcnt_q) begin
                deb_q  <= s2_q;
                dcnt_q <= '0;
            end else begin
                dcnt_q <= dcnt_q + DEBOUNCE_BITS'(1);
            end
            // Arm only once a genuinely sampled released button has been seen.
            if (vld_q[1] && s2_q && deb_q) armed_q <= 1'b1;
            step_pulse_q <= armed_q && deb_prev_q && !deb_q;
        end
    end

    always_comb begin
        src_d = step_pulse_q;
        if (state_q == RUN && mode[1]) begin
            src_d = (mode[0] ? slow_tick : fast_tick) && !halt_req && !cpu_en_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            cpu_en_q <= 1'b0;
            phase_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: if (halt_req) begin
                    state_q  <= HALTED;
                    halted_q <= 1'b1;
                end
                HALTED: if (resume && !halt_req) begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
            cpu_en_q <= src_d;
            if (cpu_en_q) phase_q <= ~phase_q;
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (scan_tick) begin
            idx_d = (idx_q == DIG_BITS'(NUM_DIGITS - 1)) ? '0 : idx_q + DIG_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            idx_q    <= '0;
            onehot_q <= NUM_DIGITS'(1);
        end else begin
            idx_q    <= idx_d;
            onehot_q <= NUM_DIGITS'(1) << idx_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign cpu_phase  = phase_q;
    assign halted     = halted_q;
    assign dig_idx    = idx_q;
    assign dig_onehot = onehot_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl: expected enable cycles and phases are queued
// as stimulus is applied and matched as cpu_en pulses appear.
module tb_cpu_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [1:0] mode;
    logic       step_btn_n;
    logic       halt_req;
    logic       resume;
    logic       cpu_en;
    logic       cpu_phase;
    logic       halted;
    logic [1:0] dig_idx;
    logic [2:0] dig_onehot;

    typedef struct {
        int cyc;
        bit phase;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    bit   phase_pending = 1'b0;
    bit   phase_exp;
    bit   scan_chk = 1'b0;

    cpu_clock_ctrl #(
        .DIV_WIDTH    (8),
        .FAST_SHIFT   (3),
        .SLOW_SHIFT   (6),
        .SCAN_SHIFT   (4),
        .DEBOUNCE_BITS(4),
        .NUM_DIGITS   (3),
        .DIG_BITS     (2)
    ) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .mode      (mode),
        .step_btn_n(step_btn_n),
        .halt_req  (halt_req),
        .resume    (resume),
        .cpu_en    (cpu_en),
        .cpu_phase (cpu_phase),
        .halted    (halted),
        .dig_idx   (dig_idx),
        .dig_onehot(dig_onehot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void push_en(input int c, input bit ph);
        exp_t e;
        e.cyc   = c;
        e.phase = ph;
        exp_q.push_back(e);
    endfunction

    // One clock: sample after the edge, then score phase, enables and scan outputs.
    task automatic step();
        exp_t e;
        int   idx;
        @(posedge clk);
        #1;
        cyc++;
        if (phase_pending) begin
            check("cpu_phase", cpu_phase, phase_exp);
            phase_pending = 1'b0;
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("cpu_en_missed", cyc, e.cyc);
        end
        if (cpu_en) begin
            if (exp_q.size() == 0) begin
                check("cpu_en_unexpected", cpu_en, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("cpu_en_cycle", cyc, e.cyc);
                phase_exp     = e.phase;
                phase_pending = 1'b1;
            end
        end
        if (scan_chk) begin
            idx = (cyc / 16) % 3;
            check("dig_idx", dig_idx, idx);
            check("dig_onehot", dig_onehot, 32'd1 << idx);
        end
    endtask

    task automatic advance_to(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        rst_in     = 1'b0;
        mode       = 2'b10;
        step_btn_n = 1'b1;
        halt_req   = 1'b0;
        resume     = 1'b0;
        cyc        = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_en", cpu_en, 1'b0);
        check("rst_cpu_phase", cpu_phase, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_dig_idx", dig_idx, 2'd0);
        check("rst_dig_onehot", dig_onehot, 3'b001);

        // Fast run: enables on the 8-cycle grid.
        rst_in = 1'b1;
        push_en(8, 1'b1);
        push_en(16, 1'b0);
        push_en(24, 1'b1);
        advance_to(24);

        // Slow run: next enable on the 64-cycle grid, none in between.
        mode = 2'b11;
        push_en(64, 1'b0);
        push_en(128, 1'b1);
        advance_to(130);
        check("slow_queue_drained", exp_q.size(), 0);

        // Button mode: short glitch ignored, long press gives one enable 20 cycles later.
        mode = 2'b00;
        advance_to(140);
        step_btn_n = 1'b0;
        advance_to(150);
        step_btn_n = 1'b1;
        advance_to(180);
        step_btn_n = 1'b0;
        push_en(200, 1'b0);
        advance_to(220);
        step_btn_n = 1'b1;
        advance_to(260);
        check("button_queue_drained", exp_q.size(), 0);

        // Halt in fast mode, single step while halted, then resume on the grid.
        mode = 2'b10;
        push_en(264, 1'b1);
        push_en(272, 1'b0);
        advance_to(276);
        check("halted_before_req", halted, 1'b0);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halted_after_req", halted, 1'b1);
        advance_to(290);
        step_btn_n = 1'b0;
        push_en(310, 1'b1);
        advance_to(330);
        step_btn_n = 1'b1;
        advance_to(355);
        check("halted_before_resume", halted, 1'b1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("halted_after_resume", halted, 1'b0);
        push_en(360, 1'b0);
        push_en(368, 1'b1);

        // halt_req coincident with a fast tick drops that enable.
        advance_to(375);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halted_on_tick", halted, 1'b1);
        advance_to(380);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("halted_resume2", halted, 1'b0);
        push_en(384, 1'b0);

        // halt_req and resume together in RUN: halt wins.
        advance_to(386);
        halt_req = 1'b1;
        resume   = 1'b1;
        step();
        halt_req = 1'b0;
        resume   = 1'b0;
        check("halt_wins", halted, 1'b1);
        advance_to(395);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("halted_resume3", halted, 1'b0);
        push_en(400, 1'b1);
        advance_to(400);

        // Scan wrap over 200 cycles with enables quiet.
        mode     = 2'b00;
        scan_chk = 1'b1;
        advance_to(600);
        scan_chk = 1'b0;
        step();
        check("final_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
